// File: rtl/compare_bitwise_64_pkg.sv
// Shared core constants for the SLT/SLTU datapath: register width and
// the width of the compare flag that is zero-extended into a writeback value.
package compare_bitwise_64_pkg;

    localparam int XLEN       = 64;
    localparam int SLT_FLAG_W = 1;
    localparam int SLT_RES_W  = XLEN;

endpackage : compare_bitwise_64_pkg

// File: rtl/compare_bitwise_64_if.sv
// Operand/result bundle between the EX-stage operand mux and the SLTU comparator.
interface compare_bitwise_64_if
    import compare_bitwise_64_pkg::*;
#(
    parameter int WIDTH = XLEN
);

    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [WIDTH-1:0] result;

    modport master (
        output rs1,
        output rs2,
        input  result
    );

    modport slave (
        input  rs1,
        input  rs2,
        output result
    );

endinterface : compare_bitwise_64_if

// File: rtl/compare_bitwise_64_cell.sv
// Single-bit unsigned compare cell: reports equality and a-less-than-b for one bit.
module cmp_bit_cell (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic lt
);

    assign eq = ~(a ^ b);
    assign lt = ~a & b;

endmodule : cmp_bit_cell

// File: rtl/compare_bitwise_64.sv
// Registered unsigned less-than (RISC-V SLTU) built from per-bit cells merged
// MSB-first by a binary tree; one result per cycle, latency one cycle.
module compare_bitwise_64
    import compare_bitwise_64_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    compare_bitwise_64_if.slave  bus
);

    localparam int NODES = 2 * WIDTH;

    // Heap-indexed tree: node n has children 2n (more significant) and 2n+1.
    // Leaf WIDTH+j holds bit WIDTH-1-j, so lower indices are more significant.
    logic w_eq [2:NODES-1];
    logic w_lt [1:NODES-1];
    logic r_lt;

    for (genvar j = 0; j < WIDTH; j++) begin : g_cell
        cmp_bit_cell u_cell (
            .a  (bus.rs1[WIDTH-1-j]),
            .b  (bus.rs2[WIDTH-1-j]),
            .eq (w_eq[WIDTH+j]),
            .lt (w_lt[WIDTH+j])
        );
    end

    for (genvar n = 2; n < WIDTH; n++) begin : g_node
        assign w_eq[n] = w_eq[2*n] & w_eq[2*n+1];
        assign w_lt[n] = w_lt[2*n] | (w_eq[2*n] & w_lt[2*n+1]);
    end

    // The root only needs lt; equality of the whole word is never consumed.
    assign w_lt[1] = w_lt[2] | (w_eq[2] & w_lt[3]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lt <= 1'b0;
        end else begin
            r_lt <= w_lt[1];
        end
    end

    assign bus.result = {{(WIDTH-SLT_FLAG_W){1'b0}}, r_lt};

endmodule : compare_bitwise_64

// File: tb/tb_compare_bitwise_64.sv
// Directed-vector and model-checked bench for the registered SLTU comparator.
module tb_compare_bitwise_64;
    import compare_bitwise_64_pkg::*;

    typedef struct {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        exp_lt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [14];

    always #5 clk = ~clk;

    compare_bitwise_64_if #(.WIDTH(XLEN)) bus ();

    compare_bitwise_64 #(.WIDTH(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_check(input string name, input logic [63:0] a, input logic [63:0] b,
                               input logic exp_lt);
        @(negedge clk);
        bus.rs1 = a;
        bus.rs2 = b;
        @(posedge clk);
        #1;
        check(name, bus.result, {63'b0, exp_lt});
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;

        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0000_0000_0010, 1'b0};
        vecs[1]  = '{64'h0000_0000_0000_0020, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1};
        vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0};
        vecs[3]  = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0};
        vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[5]  = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1};
        vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b0};
        vecs[7]  = '{64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1};
        vecs[8]  = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0};
        vecs[9]  = '{64'h0000_0000_0000_0002, 64'h0000_0000_0000_0003, 1'b1};
        vecs[10] = '{64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 1'b0};
        vecs[11] = '{64'h0000_0000_0000_1234, 64'h8000_0000_0000_1234, 1'b1};
        vecs[12] = '{64'h8000_0000_0000_1234, 64'h0000_0000_0000_1234, 1'b0};
        vecs[13] = '{64'h0000_0000_0000_0010, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1};

        // Reset held two edges with a "true" compare on the inputs.
        rst     = 1'b1;
        bus.rs1 = 64'd0;
        bus.rs2 = 64'd1;
        @(posedge clk);
        #1;
        check("reset_edge1", bus.result, 64'd0);
        @(posedge clk);
        #1;
        check("reset_edge2", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_reset", bus.result, 64'd1);

        for (int i = 0; i < 14; i++) begin
            apply_check($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2, vecs[i].exp_lt);
        end

        // Reset mid-stream must override a true compare.
        @(negedge clk);
        bus.rs1 = 64'd5;
        bus.rs2 = 64'd9;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        check("reset_midstream", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_midstream", bus.result, 64'd1);

        for (int i = 0; i < 64; i++) begin
            a = {$urandom, $urandom};
            b = a ^ (64'd1 << i);
            apply_check($sformatf("bit%0d_ab", i), a, b, a < b);
            apply_check($sformatf("bit%0d_ba", i), b, a, b < a);
        end

        for (int i = 0; i < 10000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 0) b[63:32] = a[63:32];
            if (i % 16 == 1) b = a;
            apply_check($sformatf("rand%0d", i), a, b, a < b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_compare_bitwise_64
